// File: rtl/apb_led_ctrl.sv
// APB3 LED controller: per-channel off/on/PWM/blink drive behind a
// small register file, all channels paced by one shared tick prescaler.
module apb_led_ctrl #(
    parameter int NUM_CH    = 8,
    parameter int PWM_WIDTH = 8
) (
    input  logic              io_systemClk,
    input  logic              io_systemReset,
    input  logic [15:0]       PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERROR,
    output logic [NUM_CH-1:0] o_led
);

    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_PWM   = 2'd2;
    localparam logic [1:0] MODE_BLINK = 2'd3;

    localparam logic [31:0] CFG_VAL = {16'h0, 8'(NUM_CH), 8'(PWM_WIDTH)};

    logic [5:0]  idx;
    logic [5:0]  ch_off;
    logic [3:0]  ch_sel;
    logic        is_ctrl;
    logic        is_pre;
    logic        is_cfg;
    logic        is_ch;
    logic        addr_err;
    logic        access;
    logic        wr_ok;
    logic        rd_ok;
    logic [31:0] rdata;

    logic                 en_q;
    logic                 en_d;
    logic [15:0]          prescale_q;
    logic [15:0]          prescale_d;
    logic [15:0]          pcnt_q;
    logic [15:0]          pcnt_d;
    logic [PWM_WIDTH-1:0] phase_q;
    logic [PWM_WIDTH-1:0] phase_d;
    logic                 tick;
    logic                 pre_wr;

    logic [NUM_CH-1:0] led_q;
    logic [NUM_CH-1:0] led_d;
    logic [31:0]       ch_rd [NUM_CH];

    logic unused_ok;

    // Address decode: word index only, byte lanes and high bits ignored.
    assign idx     = PADDR[7:2];
    assign ch_off  = idx - 6'd4;
    assign ch_sel  = ch_off[3:0];
    assign is_ctrl = (idx == 6'd0);
    assign is_pre  = (idx == 6'd1);
    assign is_cfg  = (idx == 6'd2);
    assign is_ch   = (idx >= 6'd4) && (idx < 6'(4 + NUM_CH));

    assign addr_err = !(is_ctrl || is_pre || is_cfg || is_ch)
                    || (is_cfg && PWRITE);

    assign access = PSEL && PENABLE && !io_systemReset;
    assign wr_ok  = access && PWRITE && !addr_err;
    assign rd_ok  = access && !PWRITE && !addr_err;
    assign pre_wr = wr_ok && is_pre;

    assign PREADY    = 1'b1;
    assign PSLVERROR = access && addr_err;
    assign PRDATA    = rd_ok ? rdata : 32'h0;

    assign unused_ok = ^{PADDR[15:8], PADDR[1:0], PWDATA[7:2], ch_off[5:4]};

    always_comb begin
        rdata = 32'h0;
        unique case (1'b1)
            is_ctrl: rdata = {31'h0, en_q};
            is_pre:  rdata = {16'h0, prescale_q};
            is_cfg:  rdata = CFG_VAL;
            is_ch: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (ch_sel == 4'(n)) begin
                        rdata = ch_rd[n];
                    end
                end
            end
            default: rdata = 32'h0;
        endcase
    end

    assign tick = en_q && (pcnt_q == prescale_q);

    // Counters only advance while enabled before and after this edge,
    // so a fresh enable always starts from a zeroed prescaler and phase.
    always_comb begin
        en_d       = en_q;
        prescale_d = prescale_q;
        pcnt_d     = 16'h0;
        phase_d    = '0;
        if (wr_ok && is_ctrl) begin
            en_d = PWDATA[0];
        end
        if (pre_wr) begin
            prescale_d = PWDATA[15:0];
        end
        if (en_d && en_q) begin
            if (!pre_wr && !tick) begin
                pcnt_d = pcnt_q + 16'd1;
            end
            phase_d = tick ? phase_q + 1'b1 : phase_q;
        end
    end

    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            en_q       <= 1'b0;
            prescale_q <= 16'h0;
            pcnt_q     <= 16'h0;
            phase_q    <= '0;
            led_q      <= '0;
        end else begin
            en_q       <= en_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            phase_q    <= phase_d;
            led_q      <= led_d;
        end
    end

    assign o_led = led_q;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [1:0]  mode_q;
        logic [1:0]  mode_d;
        logic [7:0]  duty_q;
        logic [7:0]  duty_d;
        logic [15:0] half_q;
        logic [15:0] half_d;
        logic [15:0] bcnt_q;
        logic [15:0] bcnt_d;
        logic        bst_q;
        logic        bst_d;
        logic [15:0] half_m1;
        logic        ch_wr;
        logic        pwm_on;

        assign ch_wr = wr_ok && is_ch && (ch_sel == 4'(n));

        // A write lands first; a coincident tick then acts on the new values.
        always_comb begin
            mode_d  = mode_q;
            duty_d  = duty_q;
            half_d  = half_q;
            bcnt_d  = bcnt_q;
            bst_d   = bst_q;
            if (ch_wr) begin
                mode_d = PWDATA[1:0];
                duty_d = PWDATA[15:8];
                half_d = PWDATA[31:16];
                bcnt_d = 16'h0;
                bst_d  = 1'b0;
            end
            half_m1 = (half_d == 16'h0) ? 16'h0 : half_d - 16'd1;
            if (!en_d) begin
                bcnt_d = 16'h0;
                bst_d  = 1'b0;
            end else if (tick && (mode_d == MODE_BLINK)) begin
                if (bcnt_d == half_m1) begin
                    bcnt_d = 16'h0;
                    bst_d  = !bst_d;
                end else begin
                    bcnt_d = bcnt_d + 16'd1;
                end
            end
        end

        always_ff @(posedge io_systemClk) begin
            if (io_systemReset) begin
                mode_q <= 2'd0;
                duty_q <= 8'h0;
                half_q <= 16'h0;
                bcnt_q <= 16'h0;
                bst_q  <= 1'b0;
            end else begin
                mode_q <= mode_d;
                duty_q <= duty_d;
                half_q <= half_d;
                bcnt_q <= bcnt_d;
                bst_q  <= bst_d;
            end
        end

        assign pwm_on   = phase_q < duty_q[PWM_WIDTH-1:0];
        assign ch_rd[n] = {half_q, duty_q, 6'h0, mode_q};
        assign led_d[n] = en_q && ((mode_q == MODE_ON)
                                || ((mode_q == MODE_PWM) && pwm_on)
                                || ((mode_q == MODE_BLINK) && bst_q));
    end

endmodule

// File: tb/tb_apb_led_ctrl.sv
// Bench for apb_led_ctrl: directed scenarios plus random APB traffic
// checked cycle by cycle against a tick-counting reference model.
module tb_apb_led_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] paddr;
    logic        psel_a;
    logic        psel_b;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata_a;
    logic [31:0] prdata_b;
    logic        pready_a;
    logic        pready_b;
    logic        perr_a;
    logic        perr_b;
    logic [7:0]  led_a;
    logic [3:0]  led_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    apb_led_ctrl #(.NUM_CH(8), .PWM_WIDTH(8)) u_dut (
        .io_systemClk   (clk),
        .io_systemReset (rst),
        .PADDR          (paddr),
        .PSEL           (psel_a),
        .PENABLE        (penable),
        .PWRITE         (pwrite),
        .PWDATA         (pwdata),
        .PRDATA         (prdata_a),
        .PREADY         (pready_a),
        .PSLVERROR      (perr_a),
        .o_led          (led_a)
    );

    apb_led_ctrl #(.NUM_CH(4), .PWM_WIDTH(4)) u_dut4 (
        .io_systemClk   (clk),
        .io_systemReset (rst),
        .PADDR          (paddr),
        .PSEL           (psel_b),
        .PENABLE        (penable),
        .PWRITE         (pwrite),
        .PWDATA         (pwdata),
        .PRDATA         (prdata_b),
        .PREADY         (pready_b),
        .PSLVERROR      (perr_b),
        .o_led          (led_b)
    );

    // Reference model of the 8-channel instance: registers plus tick counts.
    bit          m_en;
    logic [15:0] m_pre;
    logic [1:0]  m_mode [8];
    logic [7:0]  m_duty [8];
    logic [15:0] m_half [8];
    int          m_pc;
    int          m_ph;
    int          m_bt [8];
    logic [7:0]  m_led;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_read(input logic [15:0] a);
        int i;
        int c;
        i = int'(a[7:2]);
        if (i == 0) return {1'b0, 31'h0, m_en};
        if (i == 1) return {1'b0, 16'h0, m_pre};
        if (i == 2) return {1'b0, 32'h0000_0808};
        if (i >= 4 && i < 12) begin
            c = i - 4;
            return {1'b0, m_half[c], m_duty[c], 6'h0, m_mode[c]};
        end
        return {1'b1, 32'h0};
    endfunction

    task automatic model_edge();
        logic [7:0] nl;
        bit         tk;
        bit         old_en;
        bit         pw;
        int         h;
        int         i;
        int         c;
        for (int k = 0; k < 8; k++) begin
            h = (m_half[k] == 16'h0) ? 1 : int'(m_half[k]);
            case (m_mode[k])
                2'd1:    nl[k] = 1'b1;
                2'd2:    nl[k] = (m_ph < int'(m_duty[k]));
                2'd3:    nl[k] = ((m_bt[k] / h) % 2) == 1;
                default: nl[k] = 1'b0;
            endcase
        end
        if (!m_en) nl = 8'h0;
        if (rst) begin
            m_en = 0;
            m_pre = 16'h0;
            m_pc = 0;
            m_ph = 0;
            for (int k = 0; k < 8; k++) begin
                m_mode[k] = 2'd0;
                m_duty[k] = 8'h0;
                m_half[k] = 16'h0;
                m_bt[k] = 0;
            end
            m_led = 8'h0;
            return;
        end
        tk = m_en && (m_pc == int'(m_pre));
        old_en = m_en;
        pw = 0;
        if (psel_a && penable && pwrite) begin
            i = int'(paddr[7:2]);
            if (i == 0) m_en = pwdata[0];
            if (i == 1) begin
                m_pre = pwdata[15:0];
                pw = 1;
            end
            if (i >= 4 && i < 12) begin
                c = i - 4;
                m_mode[c] = pwdata[1:0];
                m_duty[c] = pwdata[15:8];
                m_half[c] = pwdata[31:16];
                m_bt[c] = 0;
            end
        end
        if (!m_en) begin
            m_pc = 0;
            m_ph = 0;
            for (int k = 0; k < 8; k++) m_bt[k] = 0;
        end else begin
            m_pc = (pw || !old_en || tk) ? 0 : m_pc + 1;
            if (tk) begin
                m_ph = (m_ph + 1) % 256;
                for (int k = 0; k < 8; k++) m_bt[k]++;
            end
        end
        m_led = nl;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("led", 32'(led_a), 32'(m_led));
    endtask

    task automatic apb(input bit to_b, input bit wr, input logic [15:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic err);
        paddr = a;
        pwrite = wr;
        pwdata = d;
        psel_a = !to_b;
        psel_b = to_b;
        penable = 1'b0;
        step();
        penable = 1'b1;
        #1;
        rd = to_b ? prdata_b : prdata_a;
        err = to_b ? perr_b : perr_a;
        step();
        psel_a = 1'b0;
        psel_b = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
    endtask

    task automatic wr(input bit to_b, input logic [15:0] a,
                      input logic [31:0] d);
        logic [31:0] rd;
        logic        e;
        apb(to_b, 1'b1, a, d, rd, e);
    endtask

    task automatic rd_chk(input string tag, input bit to_b,
                          input logic [15:0] a, input logic [31:0] exp_d,
                          input logic exp_e);
        logic [31:0] rd;
        logic        e;
        apb(to_b, 1'b0, a, 32'h0, rd, e);
        check(tag, rd, exp_d);
        check({tag, "_err"}, 32'(e), 32'(exp_e));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cnt;
        int          last;
        int          nch;
        int          k;
        bit          prev;
        logic [5:0]  idx;
        logic [15:0] a;
        logic [31:0] d;
        logic [31:0] rdv;
        logic        e;
        logic [32:0] exp;

        rst = 1'b1;
        paddr = 16'h0;
        psel_a = 1'b0;
        psel_b = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        pwdata = 32'h0;
        m_en = 0;
        m_pre = 16'h0;
        m_pc = 0;
        m_ph = 0;
        m_led = 8'h0;
        for (int n = 0; n < 8; n++) begin
            m_mode[n] = 2'd0;
            m_duty[n] = 8'h0;
            m_half[n] = 16'h0;
            m_bt[n] = 0;
        end

        // Accesses during reset are abandoned and read as zero.
        repeat (3) step();
        rd_chk("rst_rd_cfg", 1'b0, 16'h0008, 32'h0, 1'b0);
        rd_chk("rst_rd_0c", 1'b0, 16'h000C, 32'h0, 1'b0);
        wr(1'b0, 16'h0000, 32'h1);
        rst = 1'b0;
        step();

        check("pready", 32'(pready_a), 32'h1);
        rd_chk("cfg", 1'b0, 16'h0008, 32'h0000_0808, 1'b0);
        rd_chk("ctrl0", 1'b0, 16'h0000, 32'h0, 1'b0);
        rd_chk("pre0", 1'b0, 16'h0004, 32'h0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            rd_chk($sformatf("ch%0d_0", n), 1'b0, 16'(16 + 4 * n),
                   32'h0, 1'b0);
        end
        rd_chk("err_0c", 1'b0, 16'h000C, 32'h0, 1'b1);
        rd_chk("err_ch8", 1'b0, 16'h0030, 32'h0, 1'b1);
        rd_chk("err_50", 1'b0, 16'h0050, 32'h0, 1'b1);
        apb(1'b0, 1'b1, 16'h0008, 32'hFFFF_FFFF, rdv, e);
        check("err_cfg_wr", 32'(e), 32'h1);
        rd_chk("cfg_kept", 1'b0, 16'h0008, 32'h0000_0808, 1'b0);

        // PWM duty sweep at one tick per cycle.
        wr(1'b0, 16'h0004, 32'h0);
        wr(1'b0, 16'h0010, 32'h0000_4002);
        wr(1'b0, 16'h0000, 32'h1);
        step();
        cnt = 0;
        for (int t = 0; t < 256; t++) begin
            step();
            cnt += int'(led_a[0]);
        end
        check("pwm_64", 32'(cnt), 32'd64);
        wr(1'b0, 16'h0010, 32'h0000_0002);
        step();
        cnt = 0;
        for (int t = 0; t < 256; t++) begin
            step();
            cnt += int'(led_a[0]);
        end
        check("pwm_0", 32'(cnt), 32'd0);
        wr(1'b0, 16'h0010, 32'h0000_FF02);
        step();
        cnt = 0;
        for (int t = 0; t < 256; t++) begin
            step();
            cnt += int'(led_a[0]);
        end
        check("pwm_ff", 32'(cnt), 32'd255);

        // Blink with a 4-cycle tick and HALF=2: toggle every 8 cycles.
        wr(1'b0, 16'h0004, 32'h3);
        wr(1'b0, 16'h0014, 32'h0002_0003);
        prev = led_a[1];
        last = -1;
        nch = 0;
        for (int t = 0; t < 80 && nch < 5; t++) begin
            step();
            if (led_a[1] != prev) begin
                if (last >= 0) check("blink_per", 32'(t - last), 32'd8);
                last = t;
                prev = led_a[1];
                nch++;
            end
        end
        check("blink_seen", 32'(nch), 32'd5);

        k = 0;
        while (!led_a[1] && k < 40) begin
            step();
            k++;
        end
        check("blink_hi_seen", 32'(led_a[1]), 32'h1);
        step();
        wr(1'b0, 16'h0014, 32'h0002_0003);
        step();
        check("rewrite_low", 32'(led_a[1]), 32'h0);
        repeat (20) step();

        // Disable mid-blink, then re-enable from a clean start.
        k = 0;
        while (!led_a[1] && k < 40) begin
            step();
            k++;
        end
        check("dis_hi_seen", 32'(led_a[1]), 32'h1);
        wr(1'b0, 16'h0000, 32'h0);
        step();
        check("dis_led", 32'(led_a), 32'h0);
        repeat (10) step();
        check("dis_hold", 32'(led_a), 32'h0);
        wr(1'b0, 16'h0000, 32'h1);
        k = 0;
        for (int t = 1; t <= 40 && k == 0; t++) begin
            step();
            if (led_a[1]) k = t;
        end
        check("reen_rise", 32'(k), 32'd9);

        // Random traffic against the model.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 9) < 7) begin
                k = $urandom_range(0, 10);
                idx = 6'((k < 3) ? k : k + 1);
            end else begin
                idx = 6'($urandom_range(0, 63));
            end
            a = {8'($urandom), idx, 2'($urandom)};
            exp = ref_read(a);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                if (idx == 6'd0) d[0] = ($urandom_range(0, 4) != 0);
                if (idx == 6'd1) d[15:0] = 16'($urandom_range(0, 3));
                if (idx >= 6'd4) d[31:16] = 16'($urandom_range(0, 4));
                apb(1'b0, 1'b1, a, d, rdv, e);
                check("rnd_wr_err", 32'(e),
                      32'(exp[32] || (idx == 6'd2)));
                check("rnd_wr_prdata", rdv, 32'h0);
            end else begin
                apb(1'b0, 1'b0, a, 32'h0, rdv, e);
                check("rnd_rd", rdv, exp[31:0]);
                check("rnd_rd_err", 32'(e), 32'(exp[32]));
            end
            repeat ($urandom_range(0, 6)) step();
        end

        // Reset during a PWM run with a write in its access phase.
        wr(1'b0, 16'h0004, 32'h0);
        wr(1'b0, 16'h0010, 32'h0000_8002);
        wr(1'b0, 16'h0000, 32'h1);
        repeat (20) step();
        paddr = 16'h0018;
        pwdata = 32'hFFFF_FFFF;
        pwrite = 1'b1;
        psel_a = 1'b1;
        penable = 1'b0;
        step();
        penable = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_perr", 32'(perr_a), 32'h0);
        check("rst_prdata", prdata_a, 32'h0);
        step();
        check("rst_led", 32'(led_a), 32'h0);
        psel_a = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
        rst = 1'b0;
        step();
        rd_chk("post_ctrl", 1'b0, 16'h0000, 32'h0, 1'b0);
        rd_chk("post_pre", 1'b0, 16'h0004, 32'h0, 1'b0);
        for (int n = 0; n < 8; n++) begin
            rd_chk($sformatf("post_ch%0d", n), 1'b0, 16'(16 + 4 * n),
                   32'h0, 1'b0);
        end
        check("post_led", 32'(led_a), 32'h0);

        // Four-channel, 4-bit instance: decode limits and width.
        rd_chk("b_cfg", 1'b1, 16'h0008, 32'h0000_0404, 1'b0);
        wr(1'b1, 16'h0000, 32'h1);
        wr(1'b1, 16'h0010, 32'h0000_0001);
        wr(1'b1, 16'h0014, 32'h0000_1402);
        apb(1'b1, 1'b1, 16'h0020, 32'hFFFF_FFFF, rdv, e);
        check("b_err_ch4", 32'(e), 32'h1);
        rd_chk("b_ctrl", 1'b1, 16'h0000, 32'h1, 1'b0);
        rd_chk("b_pre", 1'b1, 16'h0004, 32'h0, 1'b0);
        rd_chk("b_ch0", 1'b1, 16'h0010, 32'h0000_0001, 1'b0);
        rd_chk("b_ch1", 1'b1, 16'h0014, 32'h0000_1402, 1'b0);
        rd_chk("b_ch2", 1'b1, 16'h0018, 32'h0, 1'b0);
        rd_chk("b_ch3", 1'b1, 16'h001C, 32'h0, 1'b0);
        rd_chk("b_ch4", 1'b1, 16'h0020, 32'h0, 1'b1);
        rd_chk("b_err_0c", 1'b1, 16'h000C, 32'h0, 1'b1);
        check("b_led0", 32'(led_b[0]), 32'h1);
        cnt = 0;
        for (int t = 0; t < 16; t++) begin
            step();
            cnt += int'(led_b[1]);
        end
        check("b_pwm_4of16", 32'(cnt), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
